regfile_wb_sched: RTL and testbench
===================================

# regfile_wb_sched

Write-back scheduler for the 32x32 register file. It shares the file's single write port among NREQ result producers, such as the ALU, the load unit and the multi-cycle unit. Requesters are served round-robin over a valid/ready handshake. A registered write command drives the register file's regwrite, writereg and writedata inputs. The block also keeps a pending-write scoreboard, so issue logic can detect read-after-write hazards on rs1 and rs2.

## Interface
- NREQ, 3, number of write-back requesters (2..4)
- XLEN, 32, data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i holds a result
- req_ready  out  NREQ  one-hot grant; a transfer happens when req_valid[i] and req_ready[i] are both high
- req_rd  in  NREQ*5  destination register, slice i = [5i+4:5i]
- req_data  in  NREQ*XLEN  result data, slice i = [XLEN*i+XLEN-1:XLEN*i]
- issue_valid  in  1  an instruction writing issue_rd was issued this cycle
- issue_rd  in  5  destination register of the issued instruction
- rs1, rs2  in  5  source registers to check
- rs1_busy, rs2_busy  out  1  a write to rs1 or rs2 is still pending
- busy_vec  out  32  scoreboard, bit r = register r pending
- rf_regwrite  out  1  register-file write enable (registered)
- rf_writereg  out  5  register-file write address (registered)
- rf_writedata  out  XLEN  register-file write data (registered)

## Operation
- Arbiter: rotating priority pointer ptr, range 0..NREQ-1, reset value 0.
  - Each cycle, req_ready grants the first i with req_valid[i] set, searching ptr, ptr+1, … modulo NREQ.
  - At most one grant per cycle.
  - If no requester is valid, req_ready is 0.
- req_ready is combinational from req_valid and ptr. It never depends on rf_* outputs, and there is no back-pressure from the register file.
- On a transfer by requester g:
  - ptr <= (g+1) mod NREQ.
  - rf_writereg <= req_rd[g], rf_writedata <= req_data[g].
  - rf_regwrite <= (req_rd[g] != 0).
- With no transfer: rf_regwrite <= 0; rf_writereg and rf_writedata hold their values.
- Requesters hold valid, rd and data stable until accepted. A request with rd = 0 is accepted and discarded: ptr advances and no write is issued.
- Scoreboard: busy[1..31] are flops; busy[0] is hard-wired to 0.
  - Set: issue_valid high with issue_rd != 0 sets busy[issue_rd].
  - Clear: rf_regwrite high clears busy[rf_writereg].
  - Same register set and cleared in the same cycle: set wins, because the new producer is outstanding.
  - issue_rd = 0 is ignored.
  - Issuing to an already-busy register is legal; the bit stays set until the next write to that register. Issue logic guarantees in-order completion per register.
- rs1_busy = busy[rs1] and rs2_busy = busy[rs2]; both are combinational from the flops. busy_vec = busy.

## Timing
- Request-to-write latency: a transfer at edge k puts rf_regwrite high during cycle k+1. The register file captures the write at edge k+1.
- The scoreboard clears busy at the same edge k+1. From cycle k+2, rs*_busy is 0 and the register file returns the new value. There is no bypass: busy never drops before the data is readable.
- Throughput: one write per cycle, sustained across any mix of requesters.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.
- Reset values (asynchronous, while rst = 0):
  - rf_regwrite = 0, rf_writereg = 0, rf_writedata = 0.
  - busy_vec = 0, ptr = 0.
  - req_ready = 0, forced low while rst is low.
- Reset mid-operation: the in-flight rf_regwrite is cancelled immediately and every pending write is forgotten. Requesters discard their state on the same reset.
- After rst deasserts, arbitration starts at the first rising edge with ptr = 0.

## Test plan
- Single request: req_valid = 001, req_rd[0] = 5, data 0xDEADBEEF at edge k. Required: req_ready = 001 in that cycle; rf_regwrite = 1, rf_writereg = 5, rf_writedata = 0xDEADBEEF in cycle k+1; rf_regwrite = 0 in cycle k+2.
- Round-robin: req_valid = 111 held for 6 cycles from reset. Required: grants 0,1,2,0,1,2. Then drop requester 1 (req_valid = 101): grants alternate 0,2.
- Scoreboard: issue_valid with issue_rd = 7 → busy_vec[7] = 1, and rs1 = 7 gives rs1_busy = 1. A write to 7 accepted at edge k → rs1_busy = 1 in cycle k+1 and 0 in cycle k+2.
- Simultaneous set and clear: rf_regwrite to register 9 and issue_rd = 9 in the same cycle → busy[9] remains 1.
- rd = 0 cases: a request with req_rd = 0 is accepted, rf_regwrite stays 0 and ptr advances. issue_rd = 0 leaves busy_vec = 0.
- Reset mid-flight: assert rst low during the cycle rf_regwrite = 1 with busy_vec = 0x00000480. Required: all outputs go to 0 at once, without waiting for a clock edge. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/regfile_wb_sched_if.sv
// rtl/regfile_wb_sched_if.sv - write-back request, scoreboard query and register-file write bundle
interface regfile_wb_sched_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [31:0]          busy_vec;
  logic                 rf_regwrite;
  logic [4:0]           rf_writereg;
  logic [XLEN-1:0]      rf_writedata;

  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, rs1, rs2,
    input  req_ready, rs1_busy, rs2_busy, busy_vec, rf_regwrite, rf_writereg, rf_writedata
  );

  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, rs1, rs2,
    output req_ready, rs1_busy, rs2_busy, busy_vec, rf_regwrite, rf_writereg, rf_writedata
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - round-robin write-back scheduler with pending-write scoreboard
module regfile_wb_sched #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_sched_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_regwrite_q, rf_regwrite_d;
  logic [4:0]      rf_writereg_q, rf_writereg_d;
  logic [XLEN-1:0] rf_writedata_q, rf_writedata_d;
  logic [31:1]     busy_q, busy_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [PW:0]     idx_w;

  // Search from ptr upward, wrapping at NREQ; the first valid requester wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx_w   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_w = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx_w >= (PW+1)'(NREQ)) idx_w = idx_w - (PW+1)'(NREQ);
      if (!gnt_any && bus.req_valid[idx_w[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_w[PW-1:0];
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d          = ptr_q;
    rf_regwrite_d  = 1'b0;
    rf_writereg_d  = rf_writereg_q;
    rf_writedata_d = rf_writedata_q;
    if (gnt_any) begin
      ptr_d          = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
      rf_writereg_d  = bus.req_rd[gnt_idx*5 +: 5];
      rf_writedata_d = bus.req_data[gnt_idx*XLEN +: XLEN];
      rf_regwrite_d  = (rf_writereg_d != 5'd0);
    end
  end

  // Clear first, then set: a freshly issued producer outranks the retiring write.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < 32; r++) begin
      if (rf_regwrite_q && rf_writereg_q == 5'(r)) busy_d[r] = 1'b0;
      if (bus.issue_valid && bus.issue_rd == 5'(r)) busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q          <= '0;
      rf_regwrite_q  <= 1'b0;
      rf_writereg_q  <= '0;
      rf_writedata_q <= '0;
      busy_q         <= '0;
    end else begin
      ptr_q          <= ptr_d;
      rf_regwrite_q  <= rf_regwrite_d;
      rf_writereg_q  <= rf_writereg_d;
      rf_writedata_q <= rf_writedata_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.req_ready    = rst ? grant : '0;
  assign bus.rf_regwrite  = rf_regwrite_q;
  assign bus.rf_writereg  = rf_writereg_q;
  assign bus.rf_writedata = rf_writedata_q;
  assign bus.busy_vec     = {busy_q, 1'b0};
  assign bus.rs1_busy     = bus.busy_vec[bus.rs1];
  assign bus.rs2_busy     = bus.busy_vec[bus.rs2];
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - scoreboard bench for regfile_wb_sched
module tb_regfile_wb_sched;
  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_sched_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

  regfile_wb_sched #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [36:0] exp_q[$];
  int          m_ptr  = 0;
  logic [31:0] m_busy = '0;
  int          m_pend = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.req_valid[i]          = v;
    bus.req_rd[5*i +: 5]      = rd;
    bus.req_data[XLEN*i +: XLEN] = d;
  endtask

  // Called just after a falling edge with inputs applied; returns the expected grant.
  task automatic step(output int g);
    logic [NREQ-1:0] exp_ready;
    logic [4:0] rd;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (g < 0 && bus.req_valid[i]) g = i;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("busy_vec", bus.busy_vec, m_busy);
    chk("rs1_busy", 32'(bus.rs1_busy), 32'(m_busy[bus.rs1]));
    chk("rs2_busy", 32'(bus.rs2_busy), 32'(m_busy[bus.rs2]));
    if (m_pend != 0) m_busy[m_pend] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != 5'd0) m_busy[bus.issue_rd] = 1'b1;
    m_pend = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      rd = bus.req_rd[5*g +: 5];
      if (rd != 5'd0) begin
        exp_q.push_back({rd, bus.req_data[XLEN*g +: XLEN]});
        m_pend = int'(rd);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req_valid = '1;
    #1;
    chk("rst_regwrite", 32'(bus.rf_regwrite), 32'd0);
    chk("rst_writereg", 32'(bus.rf_writereg), 32'd0);
    chk("rst_writedata", bus.rf_writedata, 32'd0);
    chk("rst_busy_vec", bus.busy_vec, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    exp_q.delete();
    m_ptr = 0; m_busy = '0; m_pend = 0;
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.issue_valid = 1'b0;
  endtask

  // Monitor: every cycle after the rising edge, the register-file port must match the scoreboard head.
  initial begin
    logic [36:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (exp_q.size() == 0) begin
          chk("rf_regwrite_idle", 32'(bus.rf_regwrite), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rf_regwrite", 32'(bus.rf_regwrite), 32'd1);
          if (bus.rf_regwrite) begin
            chk("rf_writereg", 32'(bus.rf_writereg), 32'(e[36:32]));
            chk("rf_writedata", bus.rf_writedata, e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    int g;
    int rr_exp[10];
    rr_exp = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};
    bus.req_valid = '0; bus.req_rd = '0; bus.req_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    do_reset();

    // Single request
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    step(g); chk("single_grant", 32'(g), 32'd0);
    bus.req_valid = '0;
    step(g); step(g);

    // Round-robin fairness, then requester 1 drops out
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h11111111);
    set_req(1, 1'b1, 5'd2, 32'h22222222);
    set_req(2, 1'b1, 5'd3, 32'h33333333);
    for (int n = 0; n < 10; n++) begin
      if (n == 6) bus.req_valid[1] = 1'b0;
      step(g);
      chk("rr_grant", 32'(g), 32'(rr_exp[n]));
    end
    bus.req_valid = '0;
    step(g);

    // Scoreboard set and clear timing
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs1 = 5'd7; bus.rs2 = 5'd3;
    step(g);
    bus.issue_valid = 1'b0;
    #1 chk("sb_busy7", 32'(bus.busy_vec[7]), 32'd1);
    chk("sb_rs1_set", 32'(bus.rs1_busy), 32'd1);
    set_req(1, 1'b1, 5'd7, 32'hCAFE0007);
    step(g);
    bus.req_valid = '0;
    #1 chk("sb_rs1_k1", 32'(bus.rs1_busy), 32'd1);
    step(g);
    #1 chk("sb_rs1_k2", 32'(bus.rs1_busy), 32'd0);

    // Same-cycle set and clear of register 9
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.rs2 = 5'd9;
    step(g);
    bus.issue_valid = 1'b0;
    set_req(2, 1'b1, 5'd9, 32'h09090909);
    step(g);
    bus.req_valid = '0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    step(g);
    bus.issue_valid = 1'b0;
    #1 chk("setclr_busy9", 32'(bus.busy_vec[9]), 32'd1);
    step(g);

    // rd = 0 requests and issues
    do_reset();
    set_req(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    step(g); chk("rd0_grant", 32'(g), 32'd0);
    bus.issue_valid = 1'b0;
    set_req(1, 1'b1, 5'd4, 32'h44444444);
    step(g); chk("rd0_ptr_adv", 32'(g), 32'd1);
    bus.req_valid = '0;
    chk("rd0_busy_vec", bus.busy_vec, 32'd0);
    step(g);

    // Reset mid-flight
    do_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    step(g);
    bus.issue_rd = 5'd10;
    step(g);
    bus.issue_valid = 1'b0;
    set_req(0, 1'b1, 5'd7, 32'h77777777);
    step(g);
    bus.req_valid = '0;
    #1 chk("mid_regwrite", 32'(bus.rf_regwrite), 32'd1);
    chk("mid_busy_vec", bus.busy_vec, 32'h00000480);
    do_reset();
    bus.req_valid = '1;
    step(g); chk("post_rst_grant", 32'(g), 32'd0);
    bus.req_valid = '0;
    step(g);

    // Random traffic; requesters hold their request until granted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && ($urandom_range(0, 2) != 0))
          set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
      end
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd = 5'($urandom_range(0, 31));
      bus.rs1 = 5'($urandom_range(0, 31));
      bus.rs2 = 5'($urandom_range(0, 31));
      step(g);
      if (g >= 0) bus.req_valid[g] = 1'b0;
    end
    bus.req_valid = '0;
    bus.issue_valid = 1'b0;
    step(g); step(g);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
